// File: rtl/stream_tx_pkg.sv
// Shared types and sizing helpers for the wide-word to AXI4-Stream transmit path.
package stream_tx_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    function automatic int unsigned lanes(input int unsigned buffer_width, input int unsigned width);
        return buffer_width / width;
    endfunction

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and head-of-queue output.
module sync_fifo
    import stream_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = idx_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Storage carries no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/buffer_stream_tx.sv
// Buffers wide words and emits them as WIDTH-wide AXI4-Stream beats, LSB lane first.
// Define BUFFER_STREAM_TX_TLAST_EN to build the frame counter driving o_tlast.
module buffer_stream_tx
    import stream_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned BUFFER_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FRAME_WORDS  = 512
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [BUFFER_WIDTH-1:0] i_data,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic [WIDTH-1:0]        o_tdata,
    output logic                    o_tlast
);

    localparam int unsigned            LANES     = lanes(BUFFER_WIDTH, WIDTH);
    localparam int unsigned            LANE_W    = idx_width(LANES);
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(LANES - 1);

    if ((BUFFER_WIDTH % WIDTH) != 0 || LANES < 1) begin : g_bad_width
        $error("BUFFER_WIDTH must be a non-zero multiple of WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (FRAME_WORDS < 1) begin : g_bad_frame
        $error("FRAME_WORDS must be >= 1");
    end

    tx_state_t               state;
    logic [BUFFER_WIDTH-1:0] r_shift;
    logic [LANE_W-1:0]       r_lane;
    logic                    r_live;
    logic [BUFFER_WIDTH-1:0] fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push_c;
    logic                    pop_c;
    logic                    beat_c;
    logic                    last_beat_c;

    // r_live keeps o_ready low during reset and for the first edge after release.
    assign o_ready     = r_live && !fifo_full;
    assign push_c      = i_valid && o_ready;
    assign beat_c      = o_tvalid && i_tready;
    assign last_beat_c = beat_c && (r_lane == LAST_LANE);
    assign pop_c       = !fifo_empty && ((state == IDLE) || last_beat_c);

    sync_fifo #(
        .WIDTH (BUFFER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_aclk),
        .rst   (i_areset),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (i_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Unpacker: r_shift holds the lanes not yet presented on o_tdata.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state    <= IDLE;
            r_shift  <= '0;
            r_lane   <= '0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else if (pop_c) begin
            state    <= SEND;
            r_shift  <= fifo_head >> WIDTH;
            r_lane   <= '0;
            o_tvalid <= 1'b1;
            o_tdata  <= fifo_head[WIDTH-1:0];
        end else if (last_beat_c) begin
            state    <= IDLE;
            o_tvalid <= 1'b0;
        end else if (beat_c) begin
            r_shift  <= r_shift >> WIDTH;
            r_lane   <= r_lane + LANE_W'(1);
            o_tdata  <= r_shift[WIDTH-1:0];
        end
    end

`ifdef BUFFER_STREAM_TX_TLAST_EN
    localparam int unsigned       WORD_W    = idx_width(FRAME_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] word_next_c;

    // Index of the word on (or about to be on) the bus after this edge.
    always_comb begin
        word_next_c = r_word;
        if (last_beat_c) begin
            word_next_c = (r_word == LAST_WORD) ? '0 : r_word + WORD_W'(1);
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_word  <= '0;
            o_tlast <= 1'b0;
        end else begin
            r_word <= word_next_c;
            if (pop_c) begin
                o_tlast <= (LANES == 1) && (word_next_c == LAST_WORD);
            end else if (last_beat_c) begin
                o_tlast <= 1'b0;
            end else if (beat_c) begin
                o_tlast <= ((r_lane + LANE_W'(1)) == LAST_LANE) && (r_word == LAST_WORD);
            end
        end
    end
`else
    assign o_tlast = 1'b0;
`endif

endmodule
